// File: rtl/axi_grant_decoder_if.sv
// ---------------------------------------------------------------------------
// axi_grant_decoder_if
// Bundles the index stream and grant-side signals of axi_grant_decoder.
//   s_index/s_valid/s_ready : encoded port index stream (valid/ready)
//   grant/grant_valid/grant_index : active one-hot grant and its index
//   release_pulse : per-port done pulse ("release" is a reserved word)
//   count : FIFO occupancy excluding the active grant
//   err   : one-cycle pulse for an accepted out-of-range index
// Modports: slave (decoder side), master (producer/consumer side).
// ---------------------------------------------------------------------------
interface axi_grant_decoder_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0]    s_index;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [IW-1:0]    grant_index;
  logic [WIDTH-1:0] release_pulse;
  logic [CW-1:0]    count;
  logic             err;

  modport slave (
    input  s_index, s_valid, release_pulse,
    output s_ready, grant, grant_valid, grant_index, count, err
  );

  modport master (
    output s_index, s_valid, release_pulse,
    input  s_ready, grant, grant_valid, grant_index, count, err
  );
endinterface

// File: rtl/axi_grant_decoder.sv
// ---------------------------------------------------------------------------
// axi_grant_decoder
// Buffers encoded port indices in a small FIFO and hands out one registered
// one-hot grant at a time, holding it until the granted port pulses release.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : axi_grant_decoder_if.slave (index stream, grant, release, status)
//
// state | meaning
// IDLE  | no grant active; pop FIFO head as soon as it is non-empty
// GRANT | one-hot grant held until release of the granted port
// ---------------------------------------------------------------------------
module axi_grant_decoder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_grant_decoder_if.slave   bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [IW:0]      WLIM = (IW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wptr_q, rptr_q;
  logic [IW-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             rdy_q, err_q;

  logic          full, empty, push, wr, pop, in_range, released;
  logic [IW-1:0] head;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // rdy_q keeps s_ready low during reset and for the cycle it is released.
  assign bus.s_ready = rdy_q & ~full;
  assign push     = bus.s_valid & bus.s_ready;
  assign in_range = ({1'b0, bus.s_index} < WLIM);
  assign wr       = push & in_range;
  assign head     = mem_q[rptr_q[AW-1:0]];
  // Only the bit of the currently granted port can end the grant.
  assign released = |(bus.release_pulse & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          grant_d = ONE << head;
          idx_d   = head;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (released) begin
          if (!empty) begin
            pop     = 1'b1;
            grant_d = ONE << head;
            idx_d   = head;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rdy_q   <= 1'b1;
      err_q   <= push & ~in_range;
      if (wr)  wptr_q <= wptr_q + CW'(1);
      if (pop) rptr_q <= rptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= bus.s_index;
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_index = idx_q;
  assign bus.count       = wptr_q - rptr_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_axi_grant_decoder.sv
// ---------------------------------------------------------------------------
// tb_axi_grant_decoder
// Directed bench for axi_grant_decoder: a WIDTH=4 instance for the main
// grant sequencing and a WIDTH=5 instance for the out-of-range index path.
// Expected grant indices are queued when pushed and popped when the grant
// is due to appear.
// ---------------------------------------------------------------------------
`define CHK(TAG, OBS, EXP) \
  begin \
    n_cmp++; \
    assert ((OBS) === (EXP)) else begin \
      n_bad++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_axi_grant_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] sbq [$];
  logic [3:0] cur_a;

  always #5 clk = ~clk;

  axi_grant_decoder_if #(.WIDTH(4), .DEPTH(4)) ifa ();
  axi_grant_decoder_if #(.WIDTH(5), .DEPTH(4)) ifb ();

  axi_grant_decoder #(.WIDTH(4), .DEPTH(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  axi_grant_decoder #(.WIDTH(5), .DEPTH(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag);
    logic [7:0] idx;
    logic [3:0] oh;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      idx   = sbq.pop_front();
      oh    = 4'b0001 << idx[1:0];
      cur_a = oh;
      `CHK(tag, ifa.grant, oh)
      `CHK(tag, ifa.grant_index, idx[1:0])
      `CHK(tag, ifa.grant_valid, 1'b1)
    end
  endtask

  task automatic expect_b(input string tag);
    logic [7:0] idx;
    logic [4:0] oh;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      idx = sbq.pop_front();
      oh  = 5'b00001 << idx[2:0];
      `CHK(tag, ifb.grant, oh)
      `CHK(tag, ifb.grant_index, idx[2:0])
    end
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    rst_n = 1'b0;
    cur_a = '0;
    repeat (3) begin
      ifa.s_index       = 2'($urandom);
      ifa.s_valid       = 1'($urandom);
      ifa.release_pulse = 4'($urandom);
      ifb.s_index       = 3'($urandom);
      ifb.s_valid       = 1'($urandom);
      ifb.release_pulse = 5'($urandom);
      tick();
    end
    `CHK("rst_grant", ifa.grant, 4'b0000)
    `CHK("rst_gvalid", ifa.grant_valid, 1'b0)
    `CHK("rst_gindex", ifa.grant_index, 2'd0)
    `CHK("rst_count", ifa.count, 3'd0)
    `CHK("rst_err", ifa.err, 1'b0)
    `CHK("rst_ready", ifa.s_ready, 1'b0)
    `CHK("rst_ready_b", ifb.s_ready, 1'b0)
    ifa.s_valid = 1'b0; ifa.s_index = '0; ifa.release_pulse = '0;
    ifb.s_valid = 1'b0; ifb.s_index = '0; ifb.release_pulse = '0;
    rst_n = 1'b1;
    #1;
    `CHK("ready_before_edge", ifa.s_ready, 1'b0)
    tick();
    `CHK("ready_after_edge", ifa.s_ready, 1'b1)
    `CHK("ready_after_edge_b", ifb.s_ready, 1'b1)

    // ---------------- single grant ----------------
    ifa.s_index = 2'd2; ifa.s_valid = 1'b1; sbq.push_back(8'd2);
    tick();
    ifa.s_valid = 1'b0;
    `CHK("single_count1", ifa.count, 3'd1)
    `CHK("single_nobypass", ifa.grant, 4'b0000)
    tick();
    expect_a("single_grant");
    `CHK("single_count0", ifa.count, 3'd0)
    ifa.release_pulse = 4'b0100;
    tick();
    ifa.release_pulse = '0;
    `CHK("single_rel_grant", ifa.grant, 4'b0000)
    `CHK("single_rel_gvalid", ifa.grant_valid, 1'b0)

    // ---------------- back-to-back ----------------
    ifa.s_valid = 1'b1;
    ifa.s_index = 2'd1; sbq.push_back(8'd1);
    tick();
    `CHK("b2b_count_e1", ifa.count, 3'd1)
    ifa.s_index = 2'd3; sbq.push_back(8'd3);
    tick();
    expect_a("b2b_g1");
    `CHK("b2b_count_e2", ifa.count, 3'd1)
    ifa.s_index = 2'd0; sbq.push_back(8'd0);
    tick();
    ifa.s_valid = 1'b0;
    `CHK("b2b_count_e3", ifa.count, 3'd2)
    `CHK("b2b_hold", ifa.grant, cur_a)
    ifa.release_pulse = cur_a;
    tick();
    expect_a("b2b_g3");
    `CHK("b2b_count_1", ifa.count, 3'd1)
    ifa.release_pulse = cur_a;
    tick();
    expect_a("b2b_g0");
    `CHK("b2b_count_0", ifa.count, 3'd0)
    ifa.release_pulse = cur_a;
    tick();
    ifa.release_pulse = '0;
    `CHK("b2b_end", ifa.grant, 4'b0000)

    // ---------------- full ----------------
    ifa.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.s_index = 2'(i % 4);
      sbq.push_back(8'(i % 4));
      tick();
    end
    expect_a("full_head");
    `CHK("full_count4", ifa.count, 3'd4)
    `CHK("full_ready0", ifa.s_ready, 1'b0)
    ifa.s_index = 2'd1;
    tick();
    `CHK("full_nopush", ifa.count, 3'd4)
    ifa.release_pulse = cur_a;
    tick();
    ifa.release_pulse = '0;
    expect_a("full_next");
    `CHK("full_count3", ifa.count, 3'd3)
    `CHK("full_ready1", ifa.s_ready, 1'b1)
    ifa.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.release_pulse = cur_a;
      tick();
      expect_a("full_drain");
    end
    ifa.release_pulse = cur_a;
    tick();
    ifa.release_pulse = '0;
    `CHK("full_empty_grant", ifa.grant, 4'b0000)
    `CHK("full_empty_count", ifa.count, 3'd0)

    // ---------------- wrong release, then reset mid-grant ----------------
    ifa.s_index = 2'd2; ifa.s_valid = 1'b1; sbq.push_back(8'd2);
    tick();
    ifa.s_valid = 1'b0;
    tick();
    expect_a("wr_grant");
    ifa.release_pulse = 4'b0001;
    tick();
    `CHK("wr_rel0", ifa.grant, 4'b0100)
    ifa.release_pulse = 4'b1000;
    tick();
    `CHK("wr_rel3", ifa.grant, 4'b0100)
    ifa.release_pulse = '0;
    ifa.s_valid = 1'b1;
    ifa.s_index = 2'd3;
    tick();
    ifa.s_index = 2'd1;
    tick();
    ifa.s_valid = 1'b0;
    `CHK("mid_count2", ifa.count, 3'd2)
    rst_n = 1'b0;
    #1;
    `CHK("mid_rst_grant", ifa.grant, 4'b0000)
    `CHK("mid_rst_gvalid", ifa.grant_valid, 1'b0)
    `CHK("mid_rst_count", ifa.count, 3'd0)
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      `CHK("post_rst_grant", ifa.grant, 4'b0000)
    end
    `CHK("post_rst_count", ifa.count, 3'd0)

    // ---------------- out of range (WIDTH=5) ----------------
    ifb.s_index = 3'd6; ifb.s_valid = 1'b1;
    tick();
    ifb.s_valid = 1'b0;
    `CHK("oor_err1", ifb.err, 1'b1)
    `CHK("oor_count", ifb.count, 3'd0)
    `CHK("oor_grant", ifb.grant, 5'b00000)
    tick();
    `CHK("oor_err0", ifb.err, 1'b0)
    `CHK("oor_grant2", ifb.grant, 5'b00000)
    ifb.s_index = 3'd4; ifb.s_valid = 1'b1; sbq.push_back(8'd4);
    tick();
    ifb.s_valid = 1'b0;
    `CHK("in4_count", ifb.count, 3'd1)
    `CHK("in4_err", ifb.err, 1'b0)
    tick();
    expect_b("in4_grant");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
